// File: rtl/frame_sched_pkg.sv
// Shared types and geometry helpers for the frame read scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWaitLine,
    StDone
  } sched_state_e;

  typedef logic [1:0] buf_idx_t;

  function automatic int unsigned line_bytes(input int unsigned h_act,
                                             input int unsigned pix_bytes);
    return h_act * pix_bytes;
  endfunction

  function automatic int unsigned bursts_per_line(input int unsigned h_act,
                                                  input int unsigned pix_bytes,
                                                  input int unsigned burst_bytes);
    return line_bytes(h_act, pix_bytes) / burst_bytes;
  endfunction

  function automatic int unsigned frame_bytes(input int unsigned h_act,
                                              input int unsigned v_act,
                                              input int unsigned pix_bytes);
    return line_bytes(h_act, pix_bytes) * v_act;
  endfunction

endpackage

// File: rtl/tri_buf_rotator.sv
// Triple-buffer bookkeeping: latest completed frame, swap on frame start,
// and selection of the buffer the writer fills next.
module tri_buf_rotator
  import frame_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_frame_done,
  input  buf_idx_t wr_buf,
  input  logic     swap,
  output buf_idx_t disp_buf,
  output buf_idx_t disp_buf_nxt,
  output buf_idx_t wr_buf_next
);

  buf_idx_t disp_q, disp_d;
  buf_idx_t latest_q, latest_d;
  logic     new_avail_q, new_avail_d;

  always_comb begin
    disp_d      = disp_q;
    latest_d    = latest_q;
    new_avail_d = new_avail_q;
    // Swap consumes the old latest; a same-cycle writer completion re-arms new_avail.
    if (swap && new_avail_q) begin
      disp_d      = latest_q;
      new_avail_d = 1'b0;
    end
    if (wr_frame_done && (wr_buf != 2'd3)) begin
      latest_d    = wr_buf;
      new_avail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q      <= 2'd0;
      latest_q    <= 2'd0;
      new_avail_q <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      latest_q    <= latest_d;
      new_avail_q <= new_avail_d;
    end
  end

  always_comb begin
    if ((disp_q != 2'd0) && (latest_q != 2'd0)) begin
      wr_buf_next = 2'd0;
    end else if ((disp_q != 2'd1) && (latest_q != 2'd1)) begin
      wr_buf_next = 2'd1;
    end else begin
      wr_buf_next = 2'd2;
    end
  end

  assign disp_buf     = disp_q;
  assign disp_buf_nxt = disp_d;

endmodule

// File: rtl/frame_read_sched.sv
// Display-side frame-buffer read scheduler: fetches each line one line ahead.
// Optional underflow statistics counter enabled by FRAME_READ_SCHED_STATS_EN.
module frame_read_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned H_ACT       = 1280,
  parameter int unsigned V_ACT       = 720,
  parameter int unsigned PIX_BYTES   = 2,
  parameter int unsigned BURST_BYTES = 256,
  parameter int unsigned FB_BASE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              read_en,
  input  logic              wr_frame_done,
  input  logic [1:0]        wr_buf,
  output logic [1:0]        wr_buf_next,
  output logic [1:0]        disp_buf,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int unsigned Bpl        = bursts_per_line(H_ACT, PIX_BYTES, BURST_BYTES);
  localparam int unsigned FrameBytes = frame_bytes(H_ACT, V_ACT, PIX_BYTES);
  localparam int unsigned BurstW     = $clog2(Bpl + 1);
  localparam int unsigned LineW      = $clog2(V_ACT + 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [LineW-1:0]  line_q, line_d;
  logic              pending_q, pending_d;
  logic              underflow_q, underflow_d;
  logic              vsync_q, read_en_q;

  logic              vsync_rise, read_en_rise, read_en_fall;
  logic              frame_start;
  buf_idx_t          disp_buf_nxt;
  logic [ADDR_W-1:0] frame_base;

  tri_buf_rotator u_rotator (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_done (wr_frame_done),
    .wr_buf        (wr_buf),
    .swap          (frame_start),
    .disp_buf      (disp_buf),
    .disp_buf_nxt  (disp_buf_nxt),
    .wr_buf_next   (wr_buf_next)
  );

  assign vsync_rise   = vsync & ~vsync_q;
  assign read_en_rise = read_en & ~read_en_q;
  assign read_en_fall = ~read_en & read_en_q;

  // Base follows the post-swap display buffer so line 0 reads the new frame.
  assign frame_base = ADDR_W'(FB_BASE) + ADDR_W'(FrameBytes) * ADDR_W'(disp_buf_nxt);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    line_d      = line_q;
    pending_d   = pending_q;
    underflow_d = 1'b0;
    frame_start = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (vsync_rise) frame_start = 1'b1;
      end
      StWaitLine: begin
        if (vsync_rise) begin
          frame_start = 1'b1;
        end else if (read_en_fall) begin
          state_d = StFetch;
          burst_d = '0;
        end
      end
      StFetch: begin
        if (vsync_rise && !pending_q) begin
          pending_d   = 1'b1;
          underflow_d = 1'b1;
        end
        if (read_en_rise) underflow_d = 1'b1;
        if (rd_ack) begin
          // A pending frame start abandons the rest of this line after the handshake.
          if (pending_q || vsync_rise) begin
            frame_start = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(BURST_BYTES);
            if (burst_q == BurstW'(Bpl - 1)) begin
              burst_d = '0;
              line_d  = line_q + 1'b1;
              state_d = (line_q + 1'b1 == LineW'(V_ACT)) ? StDone : StWaitLine;
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      state_d   = StFetch;
      addr_d    = frame_base;
      burst_d   = '0;
      line_d    = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      burst_q     <= '0;
      line_q      <= '0;
      pending_q   <= 1'b0;
      underflow_q <= 1'b0;
      vsync_q     <= 1'b0;
      read_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      line_q      <= line_d;
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
      vsync_q     <= vsync;
      read_en_q   <= read_en;
    end
  end

  assign rd_req    = (state_q == StFetch);
  assign rd_addr   = addr_q;
  assign underflow = underflow_q;

`ifdef FRAME_READ_SCHED_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = 16'd0;
`endif

endmodule
